dpram_req_scheduler: RTL and testbench
======================================

Name: dpram_req_scheduler

Overview:
- Two-lane request scheduler that sits directly upstream of the 64x16 true dual-port RAM.
- Accepts up to two ordered read/write requests per cycle and maps them onto RAM ports A and B.
- Serialises same-address hazards so that no two ports touch one address in the same cycle when either port writes.
- Returns read data in order through a credit-protected response FIFO with valid/ready.

Parameters:
AW, 6, RAM address width
DW, 16, data width
RSP_DEPTH, 4, response FIFO entries; power of 2, minimum 2

Ports:
clk  in  1  single clock; also drives both RAM port clocks
rst_n  in  1  asynchronous active-low reset
req_valid  in  2  lane valid bits; lane0 is older than lane1
req_ready  out  1  the whole pair is accepted on a clk edge where req_valid!=0 and req_ready=1
req_we  in  2  per-lane write enable (1=write, 0=read)
req_addr  in  2*AW  lane addresses; lane0 in the low bits
req_wdata  in  2*DW  lane write data
ram_ena/ram_enb  out  1  port enables
ram_wea/ram_web  out  1  port write enables
ram_addra/ram_addrb  out  AW  port addresses
ram_dia/ram_dib  out  DW  port write data
ram_doa/ram_dob  in  DW  RAM read data, registered, valid 1 cycle after enable
rsp_valid  out  1  read response available
rsp_ready  in  1  response consumer ready
rsp_data  out  DW  read data, in request order

Behaviour:
- Interface decision: one clock, clk; reset rst_n is asynchronous and active-low.
- While rst_n=0: pair stage empty, pending-read flags cleared, FIFO pointers and count zero.
  - Consequently rsp_valid=0, all ram_en*/ram_we*=0, ram addr/data=0.
  - req_ready=1 from the first edge after deassertion.
- Pair stage holds slot0 and slot1 with valid bits.
  - On acceptance, valid lanes are compacted: req_valid=2'b10 loads slot0 only.
- Credits:
  - free = RSP_DEPTH - fifo_count - pending_reads.
  - A read slot may issue only if a credit remains after older reads issued in the same cycle.
  - Writes need no credit.
- Issue logic (combinational from registered state, in-order):
  - slot0 drives port A if valid and credited.
  - slot1 drives port B only if slot0 also issues this cycle, slot1 is credited, and no conflict.
  - Conflict: addresses equal and at least one of the two is a write. Two reads to one address do not conflict.
- Stage update at each edge:
  - Issued slots are cleared.
  - If only slot0 issued, slot1 shifts into slot0.
  - req_ready=1 iff every valid slot issues this cycle (or the stage is empty). A new pair then loads in the same edge.
- Read return:
  - Per port, a pending flag is set on issue of a read.
  - The next edge pushes ram_doa, then ram_dob, into the FIFO (0, 1 or 2 pushes). Port A is older when both ports are set.
  - Write-issued ports are never pushed.
- FIFO:
  - rsp_data/rsp_valid come from the head.
  - Pop on rsp_valid&&rsp_ready.
  - Simultaneous push and pop is allowed; the credit rule guarantees no overflow.
  - Pointers wrap modulo RSP_DEPTH.
- Latency, empty FIFO, no stall: pair accepted at edge t, RAM enabled in cycle t..t+1, rsp_valid high after edge t+2. Throughput is 2 requests/cycle when there is no conflict and no credit stall.
- A write followed in a later cycle by a read of the same address returns the written data.
- Reset asserted mid-operation: in-flight requests and buffered responses are discarded, with no partial RAM access after rst_n falls.

Decomposition:
- Package dpram_sched_pkg:
  - default AW, DW and RSP_DEPTH constants;
  - request struct {we, addr, wdata};
  - helper function for the credit-count width, $clog2(RSP_DEPTH)+1.
- One natural sub-module: dpram_rsp_fifo, a 2-push/1-pop synchronous FIFO with count output and async active-low reset.

Test Plan:
- Write pair (addr3=0xAAAA, addr5=0x5555), then read pair (5,3) with rsp_ready=1 -> rsp_data 0x5555 then 0xAAAA on consecutive cycles; first rsp_valid 2 edges after read acceptance.
- Pair {lane0 write addr7=0x1234, lane1 read addr7} -> only port A enabled in the first issue cycle, req_ready=0 in that cycle; port B-free read issues next cycle; response 0x1234.
- Pair of writes to addr9 (lane0 0x1111, lane1 0x2222), then read addr9 -> serialised over 2 cycles; response 0x2222.
- rsp_ready=0 with RSP_DEPTH=4, three read pairs (addrs 0..5 preloaded 0x0100+addr) -> only 4 reads issue, req_ready stays 0, no further ram_en; raise rsp_ready -> 6 responses 0x0100..0x0105 in order, no loss or duplication.
- Two reads to the same addr in one pair -> both ports enabled in the same cycle; two identical responses.
- Assert rst_n=0 with 2 reads pending and 2 FIFO entries, release -> rsp_valid=0, req_ready=1, a fresh read returns correct RAM data.

Source files
------------

// File: rtl/dpram_req_scheduler_pkg.sv
// Shared constants and request type for the dual-port RAM request scheduler.
package dpram_sched_pkg;

  localparam int DEF_AW        = 6;
  localparam int DEF_DW        = 16;
  localparam int DEF_RSP_DEPTH = 4;

  typedef struct packed {
    logic              we;
    logic [DEF_AW-1:0] addr;
    logic [DEF_DW-1:0] wdata;
  } req_t;

  // Wide enough to hold 0..depth inclusive.
  function automatic int credit_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/dpram_req_scheduler_if.sv
// Request, RAM-port and response bundle for the scheduler; slave is the scheduler side.
interface dpram_req_scheduler_if import dpram_sched_pkg::*; #(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
);
  logic [1:0]      req_valid;
  logic            req_ready;
  logic [1:0]      req_we;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;

  logic            ram_ena, ram_enb, ram_wea, ram_web;
  logic [AW-1:0]   ram_addra, ram_addrb;
  logic [DW-1:0]   ram_dia, ram_dib, ram_doa, ram_dob;

  logic            rsp_valid, rsp_ready;
  logic [DW-1:0]   rsp_data;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready, ram_doa, ram_dob,
    input  req_ready, ram_ena, ram_enb, ram_wea, ram_web, ram_addra, ram_addrb,
           ram_dia, ram_dib, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready, ram_doa, ram_dob,
    output req_ready, ram_ena, ram_enb, ram_wea, ram_web, ram_addra, ram_addrb,
           ram_dia, ram_dib, rsp_valid, rsp_data
  );
endinterface

// File: rtl/dpram_req_scheduler_rsp_fifo.sv
// Response FIFO: up to two pushes (push1 implies push0) and one pop per cycle.
module dpram_rsp_fifo import dpram_sched_pkg::*; #(
  parameter  int DW    = DEF_DW,
  parameter  int DEPTH = DEF_RSP_DEPTH,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = credit_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push0,
  input  logic          i_push1,
  input  logic [DW-1:0] i_data0,
  input  logic [DW-1:0] i_data1,
  input  logic          i_pop,
  output logic [DW-1:0] o_data,
  output logic          o_valid,
  output logic [CW-1:0] o_count
);
  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_cnt;
  logic          w_pop;

  assign o_valid = (r_cnt != '0);
  assign w_pop   = o_valid && i_pop;
  assign o_data  = r_mem[r_rd];
  assign o_count = r_cnt;

  always_ff @(posedge clk) begin
    if (i_push0) r_mem[r_wr] <= i_data0;
    if (i_push1) r_mem[r_wr + PW'(1)] <= i_data1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      r_wr  <= r_wr + PW'(i_push0) + PW'(i_push1);
      r_rd  <= r_rd + PW'(w_pop);
      r_cnt <= r_cnt + CW'(i_push0) + CW'(i_push1) - CW'(w_pop);
    end
  end
endmodule

// File: rtl/dpram_req_scheduler.sv
// Maps an ordered request pair onto RAM ports A/B, serialising same-address
// hazards, and returns read data in order through a credit-protected FIFO.
module dpram_req_scheduler import dpram_sched_pkg::*; #(
  parameter int AW        = DEF_AW,
  parameter int DW        = DEF_DW,
  parameter int RSP_DEPTH = DEF_RSP_DEPTH
) (
  input logic                  clk,
  input logic                  rst_n,
  dpram_req_scheduler_if.slave bus
);
  localparam int CW = credit_w(RSP_DEPTH);

  req_t [1:0]    w_lane;
  req_t [1:0]    r_slot;
  logic [1:0]    r_vld;
  logic          r_pend_a, r_pend_b;
  logic [CW-1:0] w_cnt, w_free, w_need1;
  logic          w_iss0, w_iss1, w_conf, w_ready, w_acc;
  logic          w_push0, w_push1;
  logic [DW-1:0] w_pdata0;

  for (genvar i = 0; i < 2; i++) begin : g_lane
    assign w_lane[i] = '{we:    bus.req_we[i],
                         addr:  bus.req_addr[i*AW +: AW],
                         wdata: bus.req_wdata[i*DW +: DW]};
  end

  // Reads in flight in the RAM pipeline already own a FIFO slot.
  always_comb begin
    w_free  = CW'(RSP_DEPTH) - w_cnt - CW'(r_pend_a) - CW'(r_pend_b);
    w_iss0  = r_vld[0] && (r_slot[0].we || (w_free != '0));
    w_need1 = r_slot[0].we ? CW'(1) : CW'(2);
    w_conf  = (r_slot[0].addr == r_slot[1].addr) && (r_slot[0].we || r_slot[1].we);
    w_iss1  = r_vld[1] && w_iss0 && !w_conf && (r_slot[1].we || (w_free >= w_need1));
    w_ready = (!r_vld[0] || w_iss0) && (!r_vld[1] || w_iss1);
    w_acc   = w_ready && (bus.req_valid != 2'b00);
  end

  assign bus.req_ready = w_ready;

  assign bus.ram_ena   = w_iss0;
  assign bus.ram_wea   = w_iss0 && r_slot[0].we;
  assign bus.ram_addra = w_iss0 ? r_slot[0].addr : '0;
  assign bus.ram_dia   = (w_iss0 && r_slot[0].we) ? r_slot[0].wdata : '0;
  assign bus.ram_enb   = w_iss1;
  assign bus.ram_web   = w_iss1 && r_slot[1].we;
  assign bus.ram_addrb = w_iss1 ? r_slot[1].addr : '0;
  assign bus.ram_dib   = (w_iss1 && r_slot[1].we) ? r_slot[1].wdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot   <= '0;
      r_vld    <= 2'b00;
      r_pend_a <= 1'b0;
      r_pend_b <= 1'b0;
    end else begin
      r_pend_a <= w_iss0 && !r_slot[0].we;
      r_pend_b <= w_iss1 && !r_slot[1].we;
      if (w_acc) begin
        // Compact: a lone lane1 request lands in slot0.
        r_slot[0] <= bus.req_valid[0] ? w_lane[0] : w_lane[1];
        r_slot[1] <= w_lane[1];
        r_vld     <= {&bus.req_valid, 1'b1};
      end else if (w_ready) begin
        r_vld <= 2'b00;
      end else if (w_iss0) begin
        r_slot[0] <= r_slot[1];
        r_vld     <= {1'b0, r_vld[1]};
      end
    end
  end

  // Port A data is older, so it takes the first push position.
  assign w_push0  = r_pend_a || r_pend_b;
  assign w_push1  = r_pend_a && r_pend_b;
  assign w_pdata0 = r_pend_a ? bus.ram_doa : bus.ram_dob;

  dpram_rsp_fifo #(.DW(DW), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push0 (w_push0),
    .i_push1 (w_push1),
    .i_data0 (w_pdata0),
    .i_data1 (bus.ram_dob),
    .i_pop   (bus.rsp_ready),
    .o_data  (bus.rsp_data),
    .o_valid (bus.rsp_valid),
    .o_count (w_cnt)
  );
endmodule

// File: tb/tb_dpram_req_scheduler.sv
// Directed bench: behavioural 64x16 dual-port RAM behind the scheduler.
module tb_dpram_req_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dpram_req_scheduler_if #(.AW(6), .DW(16)) bus();

  dpram_req_scheduler #(.AW(6), .DW(16), .RSP_DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [15:0] ram [64];
  always @(posedge clk) begin
    if (bus.ram_ena) begin
      if (bus.ram_wea) ram[bus.ram_addra] <= bus.ram_dia;
      bus.ram_doa <= ram[bus.ram_addra];
    end
    if (bus.ram_enb) begin
      if (bus.ram_web) ram[bus.ram_addrb] <= bus.ram_dib;
      bus.ram_dob <= ram[bus.ram_addrb];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] got [8];
  int n_got;

  task automatic send(input logic [1:0] vld, input logic [1:0] we, input logic [5:0] a0,
                      input logic [5:0] a1, input logic [15:0] d0, input logic [15:0] d1);
    int n = 0;
    @(negedge clk);
    bus.req_valid = vld;
    bus.req_we    = we;
    bus.req_addr  = {a1, a0};
    bus.req_wdata = {d1, d0};
    #1;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (!bus.req_ready) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout req_ready=%0b required=1", bus.req_ready);
    end
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
  endtask

  // Gathers n responses; rsp_ready rises at a negedge so no pop goes unseen.
  task automatic collect(input int n);
    int b = 0;
    n_got = 0;
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    while (n_got < n && b < 100) begin
      if (bus.rsp_valid) begin
        got[n_got] = bus.rsp_data;
        n_got++;
      end
      @(negedge clk);
      b++;
    end
    if (n_got < n) begin
      n_tests++; n_fail++;
      $display("FAIL collect_timeout got=%0d responses required=%0d", n_got, n);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_tests++;
    if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%0b required=0", bus.rsp_valid); end
    n_tests++;
    if ({bus.ram_ena, bus.ram_enb, bus.ram_wea, bus.ram_web} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ram_en got=%b required=0000", {bus.ram_ena, bus.ram_enb, bus.ram_wea, bus.ram_web});
    end
    n_tests++;
    if ({bus.ram_addra, bus.ram_addrb, bus.ram_dia, bus.ram_dib} !== 44'h0) begin
      n_fail++; $display("FAIL reset_ram_bus got=%h required=0", {bus.ram_addra, bus.ram_addrb, bus.ram_dia, bus.ram_dib});
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got=%0b required=1", bus.req_ready); end
  endtask

  task automatic test_write_read();
    bus.rsp_ready = 1'b1;
    send(2'b11, 2'b11, 6'd3, 6'd5, 16'hAAAA, 16'h5555);
    send(2'b11, 2'b00, 6'd5, 6'd3, 16'h0, 16'h0);
    @(negedge clk);
    n_tests++;
    if ({bus.ram_ena, bus.ram_enb, bus.ram_addra, bus.ram_addrb} !== {2'b11, 6'd5, 6'd3}) begin
      n_fail++; $display("FAIL wr_rd_issue got=%h required=%h", {bus.ram_ena, bus.ram_enb, bus.ram_addra, bus.ram_addrb}, {2'b11, 6'd5, 6'd3});
    end
    n_tests++;
    if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_rd_early_t0 got=%0b required=0", bus.rsp_valid); end
    @(negedge clk);
    n_tests++;
    if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_rd_early_t1 got=%0b required=0", bus.rsp_valid); end
    @(negedge clk);
    n_tests++;
    if ({bus.rsp_valid, bus.rsp_data} !== {1'b1, 16'h5555}) begin
      n_fail++; $display("FAIL wr_rd_rsp0 got=%b/%h required=1/5555", bus.rsp_valid, bus.rsp_data);
    end
    @(negedge clk);
    n_tests++;
    if ({bus.rsp_valid, bus.rsp_data} !== {1'b1, 16'hAAAA}) begin
      n_fail++; $display("FAIL wr_rd_rsp1 got=%b/%h required=1/aaaa", bus.rsp_valid, bus.rsp_data);
    end
    @(negedge clk);
    n_tests++;
    if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_rd_drained got=%0b required=0", bus.rsp_valid); end
  endtask

  task automatic test_raw_conflict();
    send(2'b11, 2'b01, 6'd7, 6'd7, 16'h1234, 16'h0);
    @(negedge clk);
    n_tests++;
    if ({bus.ram_ena, bus.ram_wea, bus.ram_enb, bus.req_ready} !== 4'b1100) begin
      n_fail++; $display("FAIL raw_first got=%b required=1100", {bus.ram_ena, bus.ram_wea, bus.ram_enb, bus.req_ready});
    end
    @(negedge clk);
    n_tests++;
    if ({bus.ram_ena, bus.ram_wea, bus.ram_enb, bus.ram_addra} !== {3'b100, 6'd7}) begin
      n_fail++; $display("FAIL raw_second got=%h required=%h", {bus.ram_ena, bus.ram_wea, bus.ram_enb, bus.ram_addra}, {3'b100, 6'd7});
    end
    collect(1);
    n_tests++;
    if (got[0] !== 16'h1234) begin n_fail++; $display("FAIL raw_data got=%h required=1234", got[0]); end
  endtask

  task automatic test_waw();
    send(2'b11, 2'b11, 6'd9, 6'd9, 16'h1111, 16'h2222);
    @(negedge clk);
    n_tests++;
    if ({bus.ram_ena, bus.ram_wea, bus.ram_enb, bus.ram_dia} !== {3'b110, 16'h1111}) begin
      n_fail++; $display("FAIL waw_first got=%h required=%h", {bus.ram_ena, bus.ram_wea, bus.ram_enb, bus.ram_dia}, {3'b110, 16'h1111});
    end
    @(negedge clk);
    n_tests++;
    if ({bus.ram_ena, bus.ram_wea, bus.ram_enb, bus.ram_dia} !== {3'b110, 16'h2222}) begin
      n_fail++; $display("FAIL waw_second got=%h required=%h", {bus.ram_ena, bus.ram_wea, bus.ram_enb, bus.ram_dia}, {3'b110, 16'h2222});
    end
    send(2'b01, 2'b00, 6'd9, 6'd0, 16'h0, 16'h0);
    collect(1);
    n_tests++;
    if (got[0] !== 16'h2222) begin n_fail++; $display("FAIL waw_data got=%h required=2222", got[0]); end
  endtask

  task automatic test_credit_stall();
    int en_cnt = 0;
    int rdy_cnt = 0;
    send(2'b11, 2'b11, 6'd0, 6'd1, 16'h0100, 16'h0101);
    send(2'b11, 2'b11, 6'd2, 6'd3, 16'h0102, 16'h0103);
    send(2'b11, 2'b11, 6'd4, 6'd5, 16'h0104, 16'h0105);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    send(2'b11, 2'b00, 6'd0, 6'd1, 16'h0, 16'h0);
    send(2'b11, 2'b00, 6'd2, 6'd3, 16'h0, 16'h0);
    send(2'b11, 2'b00, 6'd4, 6'd5, 16'h0, 16'h0);
    repeat (6) begin
      @(negedge clk);
      en_cnt  += int'(bus.ram_ena) + int'(bus.ram_enb);
      rdy_cnt += int'(bus.req_ready);
    end
    n_tests++;
    if (en_cnt !== 0) begin n_fail++; $display("FAIL credit_no_issue got=%0d enables required=0", en_cnt); end
    n_tests++;
    if (rdy_cnt !== 0) begin n_fail++; $display("FAIL credit_ready_low got=%0d ready cycles required=0", rdy_cnt); end
    collect(6);
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if (got[i] !== 16'h0100 + 16'(i)) begin
        n_fail++; $display("FAIL credit_rsp%0d got=%h required=%h", i, got[i], 16'h0100 + 16'(i));
      end
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL credit_no_dup got=%0b required=0", bus.rsp_valid); end
  endtask

  task automatic test_same_addr_reads();
    send(2'b11, 2'b00, 6'd2, 6'd2, 16'h0, 16'h0);
    @(negedge clk);
    n_tests++;
    if ({bus.ram_ena, bus.ram_enb, bus.ram_addrb} !== {2'b11, 6'd2}) begin
      n_fail++; $display("FAIL rr_both_ports got=%h required=%h", {bus.ram_ena, bus.ram_enb, bus.ram_addrb}, {2'b11, 6'd2});
    end
    collect(2);
    n_tests++;
    if ({got[0], got[1]} !== {16'h0102, 16'h0102}) begin
      n_fail++; $display("FAIL rr_data got=%h/%h required=0102/0102", got[0], got[1]);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    send(2'b11, 2'b00, 6'd0, 6'd1, 16'h0, 16'h0);
    send(2'b11, 2'b00, 6'd2, 6'd3, 16'h0, 16'h0);
    @(posedge clk); #1;
    n_tests++;
    if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid got=%0b required=1", bus.rsp_valid); end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.rsp_valid, bus.ram_ena, bus.ram_enb} !== 3'b000) begin
      n_fail++; $display("FAIL mid_in_reset got=%b required=000", {bus.rsp_valid, bus.ram_ena, bus.ram_enb});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({bus.req_ready, bus.rsp_valid, bus.ram_ena} !== 3'b100) begin
      n_fail++; $display("FAIL mid_after_reset got=%b required=100", {bus.req_ready, bus.rsp_valid, bus.ram_ena});
    end
    send(2'b01, 2'b00, 6'd4, 6'd0, 16'h0, 16'h0);
    collect(1);
    n_tests++;
    if (got[0] !== 16'h0104) begin n_fail++; $display("FAIL mid_fresh_read got=%h required=0104", got[0]); end
  endtask

  initial begin
    bus.req_valid = 2'b00;
    bus.req_we    = 2'b00;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_write_read();
    test_raw_conflict();
    test_waw();
    test_credit_stall();
    test_same_addr_reads();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end
endmodule
